data_mem_ctrl: RTL and testbench

- Parametrised data memory for the MIPS datapath, replacing the fixed 1K x 32 word RAM.
- Byte-addressed, with byte/half/word stores via byte enables and signed/unsigned byte/half loads.
- Synchronous read with a valid/ready request and a response strobe.
- Hardware zero-clear of the whole array after reset; sits between the MEM stage and the memory array.

---
 rtl/mem_pkg.sv | 58 +++++
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/byte_en_ram.sv | 31 +++
 rtl/data_mem_ctrl.sv | 128 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data memory controller.
// Pure declarations and functions; no storage and no latency of their own.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Everything needed one cycle later to shape a load result.
  typedef struct packed {
    logic       ld;
    logic [1:0] size;
    logic [1:0] lo;
    logic       uns;
  } rsp_ctx_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = |lo;
    endcase
  endfunction

  function automatic logic [31:0] store_lane(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_lane = {4{wdata[7:0]}};
      SZ_HALF: store_lane = {2{wdata[15:0]}};
      default: store_lane = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input rsp_ctx_t ctx, input logic [31:0] word);
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = word >> {ctx.lo, 3'b000};
    half    = ctx.lo[1] ? word[31:16] : word[15:0];
    case (ctx.size)
      SZ_BYTE: load_ext = ctx.uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = ctx.uns ? {16'b0, half} : {{16{half[15]}}, half};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory controller (slave).
// Valid/ready on the request side; the response is an unconditional one-cycle strobe.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign
  );
endinterface

// File: rtl/byte_en_ram.sv
// Single-port DEPTH x 32 RAM with byte-enable write and registered read.
// Read data valid one cycle after re; no backpressure, accepts an op every cycle.
module byte_en_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Array and read register are deliberately unreset; the controller clears the array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with post-reset zero clear; loads/stores respond 1 cycle after accept.
// req_ready is low while clearing, then high every cycle (one request per cycle, no bubbles).
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus,
  output logic           init_done
);

  localparam int WAW   = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WAW;
  localparam logic [WAW-1:0] LAST_WORD = WAW'(DEPTH - 1);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("data_mem_ctrl: DATA_WIDTH must be 32");
  end

  state_e         state_q, state_d;
  logic [WAW-1:0] clr_cnt_q, clr_cnt_d;
  logic           init_done_q, init_done_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_mis_q, rsp_mis_d;
  rsp_ctx_t       ctx_q, ctx_d;

  logic           acc;
  logic           mis;
  logic           ram_we, ram_re;
  logic [3:0]     ram_be;
  logic [WAW-1:0] ram_addr;
  logic [31:0]    ram_wdata, ram_rdata;

  assign acc = bus.req_valid & req_ready_q;
  assign mis = misaligned(bus.req_size, bus.req_addr[1:0]);

  // The clear counter owns the RAM port while clearing; the request path owns it otherwise.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'b1111;
    ram_addr  = clr_cnt_q;
    ram_wdata = '0;
    if (state_q == ST_CLEAR) begin
      ram_we = 1'b1;
    end else begin
      ram_we    = acc & bus.req_we & ~mis;
      ram_re    = acc & ~bus.req_we & ~mis;
      ram_be    = byte_en(bus.req_size, bus.req_addr[1:0]);
      ram_addr  = bus.req_addr[ADDR_WIDTH-1:2];
      ram_wdata = store_lane(bus.req_size, bus.req_wdata);
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + WAW'(1);
        if (clr_cnt_q == LAST_WORD) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      default: init_done_d = 1'b1;
    endcase
    req_ready_d = (state_d == ST_IDLE);

    rsp_valid_d = acc;
    rsp_mis_d   = acc & mis;
    ctx_d       = ctx_q;
    if (acc) begin
      ctx_d.ld   = ~bus.req_we & ~mis;
      ctx_d.size = bus.req_size;
      ctx_d.lo   = bus.req_addr[1:0];
      ctx_d.uns  = bus.req_unsigned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      ctx_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mis_q   <= rsp_mis_d;
      ctx_q       <= ctx_d;
    end
  end

  byte_en_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (WAW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ctx_q and the RAM read register only move on accept, so rdata holds between responses.
  assign bus.req_ready    = req_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_misalign = rsp_mis_q;
  assign bus.rsp_rdata    = ctx_q.ld ? load_ext(ctx_q, ram_rdata) : 32'h0;
  assign init_done        = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with ADDR_WIDTH=6 (16 words).
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_WIDTH(6)) bus ();

  data_mem_ctrl #(
    .ADDR_WIDTH     (6),
    .DATA_WIDTH     (32),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .init_done (init_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [5:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  // One isolated request: accept on the next edge, then check the response strobe.
  task automatic one(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [5:0] addr, input logic [31:0] wdata,
                     input logic exp_mis, input logic [31:0] exp_rdata);
    drive(we, size, uns, addr, wdata);
    tick();
    idle();
    chk({tag, "_vld"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk({tag, "_mis"}, {31'b0, bus.rsp_misalign}, {31'b0, exp_mis});
    chk({tag, "_dat"}, bus.rsp_rdata, exp_rdata);
    tick();
    chk({tag, "_vld_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_init", {31'b0, init_done}, 32'd0);
    chk("rst_vld", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_mis", {31'b0, bus.rsp_misalign}, 32'd0);
    chk("rst_dat", bus.rsp_rdata, 32'd0);

    // Clear takes exactly DEPTH=16 cycles with req_ready low throughout
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cnt = i;
      if (init_done) break;
      if (bus.req_ready !== 1'b0) chk("clr_ready_low", {31'b0, bus.req_ready}, 32'd0);
    end
    chk("clr_cycles", cnt, 32'd16);
    chk("clr_ready_up", {31'b0, bus.req_ready}, 32'd1);
    one("lw3c_clr", 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 1'b0, 32'h0);

    // Sign/zero extension of byte and half lanes
    one("sw10", 1'b1, 2'b10, 1'b0, 6'h10, 32'h11223344, 1'b0, 32'h0);
    one("lb13", 1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 1'b0, 32'h00000011);
    one("lbu13", 1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 1'b0, 32'h00000011);
    one("lh12", 1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 1'b0, 32'h00001122);
    one("lhu10", 1'b0, 2'b01, 1'b1, 6'h10, 32'h0, 1'b0, 32'h00003344);
    one("sw20", 1'b1, 2'b10, 1'b0, 6'h20, 32'h000080FF, 1'b0, 32'h0);
    one("lb20", 1'b0, 2'b00, 1'b0, 6'h20, 32'h0, 1'b0, 32'hFFFFFFFF);
    one("lbu20", 1'b0, 2'b00, 1'b1, 6'h20, 32'h0, 1'b0, 32'h000000FF);
    one("lh20", 1'b0, 2'b01, 1'b0, 6'h20, 32'h0, 1'b0, 32'hFFFF80FF);

    // Back-to-back sw/sb/sh/lw, one response per cycle
    drive(1'b1, 2'b10, 1'b0, 6'h00, 32'hAABBCCDD);
    tick();
    chk("b2b_sw_vld", {31'b0, bus.rsp_valid}, 32'd1);
    drive(1'b1, 2'b00, 1'b0, 6'h01, 32'h0000005A);
    tick();
    chk("b2b_sb_vld", {31'b0, bus.rsp_valid}, 32'd1);
    chk("b2b_sb_dat", bus.rsp_rdata, 32'h0);
    drive(1'b1, 2'b01, 1'b0, 6'h02, 32'h00001234);
    tick();
    chk("b2b_sh_vld", {31'b0, bus.rsp_valid}, 32'd1);
    drive(1'b0, 2'b10, 1'b0, 6'h00, 32'h0);
    tick();
    idle();
    chk("b2b_lw_vld", {31'b0, bus.rsp_valid}, 32'd1);
    chk("b2b_lw_dat", bus.rsp_rdata, 32'h12345ADD);
    tick();
    chk("b2b_after_vld", {31'b0, bus.rsp_valid}, 32'd0);
    chk("b2b_hold_dat", bus.rsp_rdata, 32'h12345ADD);

    // Misaligned requests are dropped without writing
    one("sw04", 1'b1, 2'b10, 1'b0, 6'h04, 32'hCAFEF00D, 1'b0, 32'h0);
    one("lh05_mis", 1'b0, 2'b01, 1'b0, 6'h05, 32'h0, 1'b1, 32'h0);
    one("sw06_mis", 1'b1, 2'b10, 1'b0, 6'h06, 32'h99999999, 1'b1, 32'h0);
    one("sh05_mis", 1'b1, 2'b01, 1'b0, 6'h05, 32'h00007777, 1'b1, 32'h0);
    one("lw04", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 1'b0, 32'hCAFEF00D);
    one("lb05", 1'b0, 2'b00, 1'b0, 6'h05, 32'h0, 1'b0, 32'hFFFFFFF0);
    one("lrsv04", 1'b0, 2'b11, 1'b1, 6'h04, 32'h0, 1'b0, 32'hCAFEF00D);
    one("lrsv06_mis", 1'b0, 2'b11, 1'b0, 6'h06, 32'h0, 1'b1, 32'h0);

    // Dirty the last word, then reset mid-clear; clear must restart and wipe it
    one("sw3c", 1'b1, 2'b10, 1'b0, 6'h3C, 32'hDEADBEEF, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("mid_rst_init", {31'b0, init_done}, 32'd0);
    tick();
    drive(1'b0, 2'b10, 1'b0, 6'h3C, 32'h0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      cnt = i;
      if (bus.rsp_valid !== 1'b0) chk("clr_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      if (init_done) break;
    end
    chk("reclr_cycles", cnt, 32'd16);
    tick();
    idle();
    chk("reclr_lw_vld", {31'b0, bus.rsp_valid}, 32'd1);
    chk("reclr_lw_dat", bus.rsp_rdata, 32'h0);
    tick();
    chk("reclr_vld_drop", {31'b0, bus.rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
